// File: rtl/bram_rd_stream.sv
// bram_rd_stream: sweeps BRAM addresses 0..N-1 into a valid/ready stream via a 2-entry skid buffer.
// Optional checksum on o_sum when BRAM_RD_SUM_EN is defined.
module bram_rd_stream #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 8,
  parameter int MEM_SIZE = 127
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_run,
  input  logic [AWIDTH-1:0]        i_num_cnt,
  output logic [AWIDTH-1:0]        addr0,
  output logic                     ce0,
  output logic                     we0,
  input  logic [DWIDTH-1:0]        q0,
  output logic                     o_valid,
  output logic [DWIDTH-1:0]        o_data,
  output logic                     o_last,
  input  logic                     i_ready,
  output logic                     o_idle,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [DWIDTH+AWIDTH-1:0] o_sum
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [AWIDTH-1:0] MAXN = AWIDTH'(MEM_SIZE + 1);
  state_t state_q, state_d;
  logic [AWIDTH-1:0] num_q, num_d, rd_q, rd_d, pop_q, pop_d;
  logic [DWIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
  logic [1:0] occ_q, occ_d;
  logic infl_q, issue, pop, start;
  assign start   = state_q == IDLE && i_run;
  assign o_valid = occ_q != 2'd0;
  assign pop     = o_valid && i_ready;
  assign o_data  = b0_q;
  assign o_last  = o_valid && pop_q == num_q - 1'b1;
  // credit counts the buffer plus the read in flight, less this cycle's pop
  assign issue   = state_q == RUN && rd_q < num_q && (occ_q + 2'(infl_q) - 2'(pop)) < 2'd2;
  assign ce0     = issue;
  assign addr0   = issue ? rd_q : '0;
  assign we0     = 1'b0;
  assign o_idle  = state_q == IDLE;
  assign o_busy  = state_q == RUN || state_q == DRAIN;
  assign o_done  = state_q == DONE;
  always_comb begin
    state_d = start ? (i_num_cnt == '0 ? DONE : RUN)
            : (state_q == RUN && rd_q == num_q) ? DRAIN
            : (state_q == DRAIN && pop && o_last) ? DONE
            : (state_q == DONE) ? IDLE : state_q;
    num_d = start ? (i_num_cnt > MAXN ? MAXN : i_num_cnt) : num_q;
    rd_d  = start ? '0 : rd_q + AWIDTH'(issue);
    pop_d = start ? '0 : pop_q + AWIDTH'(pop);
    occ_d = occ_q - 2'(pop);
    b0_d  = pop ? b1_q : b0_q;
    b1_d  = b1_q;
    if (infl_q) begin
      if (occ_d == 2'd0) b0_d = q0;
      else b1_d = q0;
      occ_d = occ_d + 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      rd_q    <= '0;
      pop_q   <= '0;
      occ_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rd_q    <= rd_d;
      pop_q   <= pop_d;
      occ_q   <= occ_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      infl_q  <= issue;
    end
  end
`ifdef BRAM_RD_SUM_EN
  logic [DWIDTH+AWIDTH-1:0] sum_q;
  always_ff @(posedge clk) begin
    if (reset || start) sum_q <= '0;
    else if (pop) sum_q <= sum_q + (DWIDTH+AWIDTH)'(o_data);
  end
  assign o_sum = sum_q;
`else
  assign o_sum = '0;
`endif
endmodule

// File: tb/tb_bram_rd_stream.sv
// tb_bram_rd_stream: directed scenario tasks with inline checks against hand-derived timing.
module tb_bram_rd_stream;
  localparam int DW = 8, AW = 8, MS = 127, SW = DW + AW;
  logic clk = 1'b0, reset = 1'b1, i_run = 1'b0, i_ready = 1'b1;
  logic [AW-1:0] i_num_cnt = '0;
  logic [AW-1:0] addr0;
  logic ce0, we0, o_valid, o_last, o_idle, o_busy, o_done;
  logic [DW-1:0] q0, o_data;
  logic [SW-1:0] o_sum;
  logic [DW-1:0] mem [0:MS];
  int checks = 0, errors = 0;

  bram_rd_stream #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
    .addr0(addr0), .ce0(ce0), .we0(we0), .q0(q0),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .o_sum(o_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ce0) q0 <= mem[addr0];

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] sum_exp(input int n);
`ifdef BRAM_RD_SUM_EN
    return SW'(n * (n - 1) / 2);
`else
    return SW'(n * 0);
`endif
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    checks++;
    if ({o_idle, o_busy, o_done, o_valid, o_last, ce0, we0} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags got %b want 1000000", {o_idle, o_busy, o_done, o_valid, o_last, ce0, we0});
    end
    checks++;
    if (addr0 !== '0 || o_data !== '0 || o_sum !== '0) begin
      errors++;
      $display("FAIL reset_values addr0=%0d data=%0d sum=%0d want 0", addr0, o_data, o_sum);
    end
  endtask

  task automatic test_full(input int n);
    int m;
    logic exp_ce, exp_v, exp_last, exp_done, exp_idle, exp_busy;
    logic [AW-1:0] exp_addr;
    m = n > MS + 1 ? MS + 1 : n;
    i_ready = 1'b1;
    i_num_cnt = AW'(n);
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    for (int c = 1; c <= m + 4; c++) begin
      exp_ce = c <= m;
      exp_addr = exp_ce ? AW'(c - 1) : '0;
      exp_v = c >= 3 && c <= m + 2;
      exp_last = c == m + 2;
      exp_done = c == m + 3;
      exp_idle = c == m + 4;
      exp_busy = c <= m + 2;
      checks++;
      if ({ce0, addr0, o_valid, o_last, o_done, o_idle, o_busy} !==
          {exp_ce, exp_addr, exp_v, exp_last, exp_done, exp_idle, exp_busy}) begin
        errors++;
        $display("FAIL full_n%0d_c%0d got ce=%b a=%0d v=%b l=%b d=%b i=%b b=%b want ce=%b a=%0d v=%b l=%b d=%b i=%b b=%b",
                 n, c, ce0, addr0, o_valid, o_last, o_done, o_idle, o_busy,
                 exp_ce, exp_addr, exp_v, exp_last, exp_done, exp_idle, exp_busy);
      end
      if (exp_v) begin
        checks++;
        if (o_data !== DW'(c - 3)) begin
          errors++;
          $display("FAIL full_data_n%0d_c%0d got %0d want %0d", n, c, o_data, c - 3);
        end
      end
      if (c == m + 4) begin
        checks++;
        if (o_sum !== sum_exp(m)) begin
          errors++;
          $display("FAIL full_sum_n%0d got %0d want %0d", n, o_sum, sum_exp(m));
        end
      end
      if (c < m + 4) tick;
    end
  endtask

  task automatic test_zero;
    i_num_cnt = '0;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    checks++;
    if ({ce0, o_valid, o_done, o_idle, o_busy} !== 5'b00100) begin
      errors++;
      $display("FAIL zero_c1 got %b want 00100", {ce0, o_valid, o_done, o_idle, o_busy});
    end
    tick;
    checks++;
    if ({ce0, o_valid, o_done, o_idle, o_busy} !== 5'b00010 || o_sum !== '0) begin
      errors++;
      $display("FAIL zero_c2 got %b sum=%0d want 00010 sum=0", {ce0, o_valid, o_done, o_idle, o_busy}, o_sum);
    end
  endtask

  task automatic test_backpressure;
    int exp_idx = 0, issued = 0, popped = 0, k = 0;
    logic [DW-1:0] held = '0;
    logic stalled = 1'b0, done_seen = 1'b0;
    i_num_cnt = 8'd8;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    while (!done_seen && k < 100) begin
      i_ready = (k % 4 == 0) || (k % 4 == 3);
      #1;
      checks++;
      if (issued - popped > 2) begin
        errors++;
        $display("FAIL bp_credit k=%0d got %0d want <=2", k, issued - popped);
      end
      if (ce0) begin
        checks++;
        if (addr0 !== AW'(issued)) begin
          errors++;
          $display("FAIL bp_addr got %0d want %0d", addr0, issued);
        end
        issued++;
      end
      if (stalled) begin
        checks++;
        if (!o_valid || o_data !== held) begin
          errors++;
          $display("FAIL bp_hold got v=%b d=%0d want v=1 d=%0d", o_valid, o_data, held);
        end
      end
      if (o_valid) begin
        checks++;
        if (o_data !== DW'(exp_idx) || o_last !== (exp_idx == 7)) begin
          errors++;
          $display("FAIL bp_data got d=%0d l=%b want d=%0d l=%b", o_data, o_last, exp_idx, exp_idx == 7);
        end
      end
      stalled = o_valid && !i_ready;
      held = o_data;
      if (o_valid && i_ready) begin
        exp_idx++;
        popped++;
      end
      done_seen = o_done;
      k++;
      tick;
    end
    i_ready = 1'b1;
    checks++;
    if (!done_seen || exp_idx != 8 || issued != 8 || o_sum !== sum_exp(8)) begin
      errors++;
      $display("FAIL bp_total got done=%b words=%0d issues=%0d sum=%0d want 1 8 8 %0d",
               done_seen, exp_idx, issued, o_sum, sum_exp(8));
    end
  endtask

  task automatic test_stall;
    int pulses = 0, idx = 0, k = 0;
    i_ready = 1'b0;
    i_num_cnt = 8'd5;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (ce0) pulses++;
      if (c >= 3) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'd0) begin
          errors++;
          $display("FAIL stall_hold_c%0d got v=%b d=%0d want v=1 d=0", c, o_valid, o_data);
        end
      end
      if (c < 10) tick;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL stall_issues got %0d want 2", pulses);
    end
    i_ready = 1'b1;
    while (idx < 5 && k < 20) begin
      if (o_valid) begin
        checks++;
        if (o_data !== DW'(idx) || o_last !== (idx == 4)) begin
          errors++;
          $display("FAIL stall_data got d=%0d l=%b want d=%0d l=%b", o_data, o_last, idx, idx == 4);
        end
        idx++;
      end
      k++;
      tick;
    end
    checks++;
    if (idx != 5 || o_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_end got words=%0d done=%b want 5 1", idx, o_done);
    end
    tick;
  endtask

  task automatic test_reset_midrun;
    i_ready = 1'b1;
    i_num_cnt = 8'd16;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    repeat (4) tick;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'd2) begin
      errors++;
      $display("FAIL mid_pre got v=%b d=%0d want v=1 d=2", o_valid, o_data);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({o_idle, o_busy, o_done, o_valid, o_last, ce0, we0} !== 7'b1000000 ||
        addr0 !== '0 || o_data !== '0 || o_sum !== '0) begin
      errors++;
      $display("FAIL mid_reset got flags=%b a=%0d d=%0d s=%0d want 1000000 0 0 0",
               {o_idle, o_busy, o_done, o_valid, o_last, ce0, we0}, addr0, o_data, o_sum);
    end
    i_num_cnt = 8'd2;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    tick;
    tick;
    checks++;
    if ({o_valid, o_last} !== 2'b10 || o_data !== 8'd0) begin
      errors++;
      $display("FAIL mid_w0 got v=%b l=%b d=%0d want 1 0 0", o_valid, o_last, o_data);
    end
    tick;
    checks++;
    if ({o_valid, o_last} !== 2'b11 || o_data !== 8'd1) begin
      errors++;
      $display("FAIL mid_w1 got v=%b l=%b d=%0d want 1 1 1", o_valid, o_last, o_data);
    end
    tick;
    checks++;
    if (o_done !== 1'b1 || o_valid !== 1'b0 || o_sum !== sum_exp(2)) begin
      errors++;
      $display("FAIL mid_done got done=%b v=%b sum=%0d want 1 0 %0d", o_done, o_valid, o_sum, sum_exp(2));
    end
    tick;
  endtask

  initial begin
    for (int i = 0; i <= MS; i++) mem[i] = DW'(i);
    test_reset;
    test_full(4);
    test_zero;
    test_backpressure;
    test_stall;
    test_full(200);
    test_reset_midrun;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
